// File: rtl/gm64_pkg.sv
// Shared memory-bus types and widths for the block-RAM responder.
package gm64_pkg;

    typedef enum logic [1:0] {RR_IDLE, RR_WAIT, RR_CLEAR} RespState;

    localparam int MEM_ADDR_W = 24;
    localparam int MEM_DATA_W = 8;

    // True when every address bit at or above depth_w is zero.
    function automatic logic addr_in_range(input logic [MEM_ADDR_W-1:0] addr, input int depth_w);
        return (addr >> depth_w) == '0;
    endfunction

endpackage

// File: rtl/ram_responder_array.sv
// Single-port synchronous RAM with registered read data; maps onto block RAM.
module ram_responder_array
    import gm64_pkg::*;
#(
    parameter int DEPTH_W = 12
)(
    input  logic                  clkSys,
    input  logic                  we,
    input  logic [DEPTH_W-1:0]    addr,
    input  logic [MEM_DATA_W-1:0] din,
    output logic [MEM_DATA_W-1:0] dout
);

    logic [MEM_DATA_W-1:0] mem [2**DEPTH_W];

    always_ff @(posedge clkSys) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-bus responder backed by on-chip RAM: one request at a time, fixed LATENCY.
// Define RAM_RESPONDER_CLEAR_EN to fill the whole array with FILL_BYTE after every reset.
module ram_responder
    import gm64_pkg::*;
#(
    parameter int                    DEPTH_W   = 12,
    parameter int                    LATENCY   = 2,
    parameter logic [MEM_DATA_W-1:0] FILL_BYTE = 8'h00
)(
    input  logic                  i_clkRAM,
    input  logic                  reset,
    input  logic                  i_cs,
    input  logic                  i_write,
    input  logic [MEM_ADDR_W-1:0] i_address,
    input  logic [MEM_DATA_W-1:0] i_dataToWrite,
    output logic [MEM_DATA_W-1:0] o_dataRead,
    output logic                  o_busy,
    output logic                  o_dataReady
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    RespState              state;
    logic                  armed;
    logic [3:0]            count;
    logic                  req_write;
    logic                  req_in_range;
    logic [DEPTH_W-1:0]    req_addr;
    logic [MEM_DATA_W-1:0] req_data;
`ifdef RAM_RESPONDER_CLEAR_EN
    logic [DEPTH_W-1:0]    clear_addr;
`endif

    logic                  accept;
    logic                  done;
    logic                  ram_we;
    logic [DEPTH_W-1:0]    ram_addr;
    logic [MEM_DATA_W-1:0] ram_din;
    logic [MEM_DATA_W-1:0] ram_dout;

    assign accept = (state == RR_IDLE) && !i_cs && armed;
    assign done   = (state == RR_WAIT) && (count == '0);

    // In IDLE the RAM looks at the live address so a LATENCY=1 read has data one edge later.
    always_comb begin
        ram_we   = done && req_write && req_in_range;
        ram_addr = (state == RR_IDLE) ? i_address[DEPTH_W-1:0] : req_addr;
        ram_din  = req_data;
`ifdef RAM_RESPONDER_CLEAR_EN
        if (state == RR_CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clear_addr;
            ram_din  = FILL_BYTE;
        end
`endif
    end

    ram_responder_array #(.DEPTH_W(DEPTH_W)) u_array (
        .clkSys (i_clkRAM),
        .we     (ram_we),
        .addr   (ram_addr),
        .din    (ram_din),
        .dout   (ram_dout)
    );

    always_ff @(posedge i_clkRAM or posedge reset) begin
        if (reset) begin
            armed        <= 1'b1;
            count        <= '0;
            req_write    <= 1'b0;
            req_in_range <= 1'b0;
            req_addr     <= '0;
            req_data     <= '0;
            o_dataRead   <= '0;
            o_dataReady  <= 1'b0;
`ifdef RAM_RESPONDER_CLEAR_EN
            state        <= RR_CLEAR;
            o_busy       <= 1'b1;
            clear_addr   <= '0;
`else
            state        <= RR_IDLE;
            o_busy       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                armed <= 1'b0;
            end else if (i_cs) begin
                armed <= 1'b1;
            end

            case (state)
                RR_IDLE: begin
                    if (accept) begin
                        state        <= RR_WAIT;
                        o_busy       <= 1'b1;
                        o_dataReady  <= 1'b0;
                        count        <= CNT_INIT;
                        req_write    <= i_write;
                        req_in_range <= addr_in_range(i_address, DEPTH_W);
                        req_addr     <= i_address[DEPTH_W-1:0];
                        req_data     <= i_dataToWrite;
                    end
                end
                RR_WAIT: begin
                    if (count == '0) begin
                        state  <= RR_IDLE;
                        o_busy <= 1'b0;
                        if (!req_write) begin
                            o_dataReady <= 1'b1;
                            o_dataRead  <= req_in_range ? ram_dout : FILL_BYTE;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
`ifdef RAM_RESPONDER_CLEAR_EN
                RR_CLEAR: begin
                    clear_addr <= clear_addr + 1'b1;
                    if (clear_addr == '1) begin
                        state  <= RR_IDLE;
                        o_busy <= 1'b0;
                    end
                end
`endif
                default: state <= RR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed table, corner sequences, randomized traffic.
`timescale 1ns/1ps
module tb_ram_responder;

    localparam int         DEPTH_W = 12;
    localparam int         LAT     = 2;
    localparam int         LAT4    = 4;
    localparam logic [7:0] FILL    = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, cs4, wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rd, rd4;
    logic        busy, busy4, rdy, rdy4;

    always #5 clk = ~clk;

    ram_responder #(.DEPTH_W(DEPTH_W), .LATENCY(LAT), .FILL_BYTE(FILL)) u_dut (
        .i_clkRAM(clk), .reset(reset), .i_cs(cs), .i_write(wr), .i_address(addr),
        .i_dataToWrite(wdata), .o_dataRead(rd), .o_busy(busy), .o_dataReady(rdy)
    );

    ram_responder #(.DEPTH_W(DEPTH_W), .LATENCY(LAT4), .FILL_BYTE(FILL)) u_dut4 (
        .i_clkRAM(clk), .reset(reset), .i_cs(cs4), .i_write(wr), .i_address(addr),
        .i_dataToWrite(wdata), .o_dataRead(rd4), .o_busy(busy4), .o_dataReady(rdy4)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: known RAM contents plus the last visible read result.
    logic [7:0] mem_m [int];
    logic [7:0] last_rd;
    logic       last_rdy;

    typedef struct {
        bit          w;
        logic [23:0] a;
        logic [7:0]  d;
        bit          exp_rdy;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic bit in_range(input logic [23:0] a);
        return int'(a) < (1 << DEPTH_W);
    endfunction

    function automatic void model_apply(input bit w, input logic [23:0] a, input logic [7:0] d);
        if (w) begin
            if (in_range(a)) mem_m[int'(a)] = d;
            last_rdy = 1'b0;
        end else begin
            last_rdy = 1'b1;
            last_rd  = in_range(a) ? mem_m[int'(a)] : FILL;
        end
    endfunction

    // One request with cs low for a single cycle; bus inputs scrambled after acceptance.
    task automatic txn(input bit w, input logic [23:0] a, input logic [7:0] d, input string name);
        int n = 0;
        @(posedge clk); #1;
        cs = 1'b0; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b1; wr = ~w; addr = 24'($urandom); wdata = 8'($urandom);
        model_apply(w, a, d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (n == 0) check({name, ".rdy_clr"}, 32'(rdy), 32'd0);
            n++;
        end
        check({name, ".busy_len"}, 32'(n), 32'(LAT));
        check({name, ".ready"}, 32'(rdy), 32'(last_rdy));
        check({name, ".data"}, 32'(rd), 32'(last_rd));
    endtask

    task automatic do_reset(input string name);
        int n = 0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
`ifdef RAM_RESPONDER_CLEAR_EN
        check({name, ".busy"}, 32'(busy), 32'd1);
`else
        check({name, ".busy"}, 32'(busy), 32'd0);
`endif
        check({name, ".ready"}, 32'(rdy), 32'd0);
        check({name, ".data"}, 32'(rd), 32'd0);
        check({name, ".ready4"}, 32'(rdy4), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        last_rd  = 8'h00;
        last_rdy = 1'b0;
`ifdef RAM_RESPONDER_CLEAR_EN
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check({name, ".clear_len"}, 32'(n), 32'(1 << DEPTH_W));
        mem_m.delete();
        for (int i = 0; i < (1 << DEPTH_W); i++) mem_m[i] = FILL;
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, bcyc, rdy_lost, n;
        bit prev, seen_done;

        tbl[0]  = '{1'b1, 24'h000FFC, 8'hA5, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 24'h000FFC, 8'h00, 1'b1, 8'hA5};
        tbl[2]  = '{1'b1, 24'h000000, 8'h11, 1'b0, 8'hA5};
        tbl[3]  = '{1'b1, 24'h001000, 8'h3C, 1'b0, 8'hA5};
        tbl[4]  = '{1'b0, 24'h000000, 8'h00, 1'b1, 8'h11};
        tbl[5]  = '{1'b0, 24'h010000, 8'h00, 1'b1, 8'h00};
        tbl[6]  = '{1'b0, 24'h001000, 8'h00, 1'b1, 8'h00};
        tbl[7]  = '{1'b1, 24'hFFFFFF, 8'h5A, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 24'hFFFFFF, 8'h00, 1'b1, 8'h00};
        tbl[9]  = '{1'b1, 24'h000FFF, 8'h22, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 24'h000FFF, 8'h00, 1'b1, 8'h22};
        tbl[11] = '{1'b0, 24'h000FFC, 8'h00, 1'b1, 8'hA5};

        reset = 1'b1; cs = 1'b1; cs4 = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
        last_rd = 8'h00; last_rdy = 1'b0;
        do_reset("rst0");

        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_rdy", i), 32'(rdy), 32'(tbl[i].exp_rdy));
            check($sformatf("vec%0d.tbl_rd", i), 32'(rd), 32'(tbl[i].exp_rd));
        end

        // cs held low ~10 cycles: one acceptance only
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; addr = 24'h000FFC;
        pulses = 0; bcyc = 0; rdy_lost = 0; prev = 1'b0; seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && !prev) pulses++;
            if (busy) bcyc++;
            if (prev && !busy) seen_done = 1'b1;
            if (seen_done && !rdy) rdy_lost++;
            prev = busy;
        end
        #1 cs = 1'b1;
        check("hold.pulses", 32'(pulses), 32'd1);
        check("hold.busy_cycles", 32'(bcyc), 32'(LAT));
        check("hold.rdy_lost", 32'(rdy_lost), 32'd0);
        check("hold.rdy", 32'(rdy), 32'd1);
        check("hold.data", 32'(rd), 32'hA5);

        do_reset("rst_mid");

        // reset during an in-flight write of 77 to address 0
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b1; addr = 24'h0; wdata = 8'h77;
        @(posedge clk); #1;
        cs = 1'b1;
        do_reset("rst_wait");
        txn(1'b0, 24'h0, 8'h00, "after_rst");
        check("after_rst.not77", 32'(rd == 8'h77), 32'd0);

        // LATENCY=4 instance: cs low through busy is ignored until re-armed
        @(posedge clk); #1;
        cs4 = 1'b0; wr = 1'b1; addr = 24'h5; wdata = 8'h99;
        @(posedge clk); #1;
        cs4 = 1'b1;
        repeat (LAT4 + 1) @(posedge clk);
        #1 cs4 = 1'b0; wr = 1'b0; addr = 24'h5;
        @(posedge clk); #1;
        wr = 1'b1; addr = 24'h6;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy4) break;
            n++;
        end
        check("l4.busy_len", 32'(n), 32'(LAT4));
        check("l4.rdy", 32'(rdy4), 32'd1);
        check("l4.data", 32'(rd4), 32'h99);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("l4.no_requeue%0d", i), 32'(busy4), 32'd0);
        end
        check("l4.rdy_held", 32'(rdy4), 32'd1);
        @(posedge clk); #1;
        cs4 = 1'b1; wr = 1'b0; addr = 24'h010000;
        @(posedge clk); #1;
        cs4 = 1'b0;
        @(posedge clk); #1;
        cs4 = 1'b1;
        @(negedge clk);
        check("l4.rearm_busy", 32'(busy4), 32'd1);
        check("l4.rearm_rdy_clr", 32'(rdy4), 32'd0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy4) break;
            n++;
        end
        check("l4.rearm_busy_len", 32'(n), 32'(LAT4));
        check("l4.rearm_rdy", 32'(rdy4), 32'd1);
        check("l4.rearm_fill", 32'(rd4), 32'(FILL));

        // randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            bit          w;
            int          sel;
            logic [23:0] a;
            w   = 1'($urandom);
            sel = int'($urandom_range(0, 39));
            if (sel < 16)      a = 24'(sel);
            else if (sel < 32) a = 24'((1 << DEPTH_W) - 32 + sel);
            else               a = 24'h001000 + 24'($urandom % 32'hFFF000);
            if (!w && in_range(a) && !mem_m.exists(int'(a))) w = 1'b1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            txn(w, a, 8'($urandom), $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
